// File: rtl/fsm_mod_counter.sv
// Parametrised mod-N counter behind an IDLE / WAIT_LOAD / RUN state machine.
// Registered count and flags let carry_out of one stage drive cnt_en of the next.
module fsm_mod_counter #(
   parameter int WIDTH   = 6,
   parameter int MODULUS = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             cnt_in_load,
   input  logic             cnt_en,
   input  logic             cnt_dir,
   output logic [WIDTH-1:0] cnt_out,
   output logic             carry_out,
   output logic             load_err,
   output logic             running
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_LOAD = 2'b01,
      RUN       = 2'b10
   } state_t;

   // The extra bit keeps the range check exact when MODULUS == 2**WIDTH.
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] cnt_nxt;
   logic             carry_nxt;
   logic             err_nxt;
   logic             load_ok;

   assign load_ok = ({1'b0, cnt_in} < MOD_EXT);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_nxt = state;
      cnt_nxt   = cnt_out;
      carry_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = WAIT_LOAD;
         end
         WAIT_LOAD: begin
            if (cnt_in_load) begin
               if (load_ok) begin
                  state_nxt = RUN;
                  cnt_nxt   = cnt_in;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            // A rejected load still claims the cycle, so no step happens.
            if (cnt_in_load) begin
               if (load_ok) cnt_nxt = cnt_in;
               else         err_nxt = 1'b1;
            end else if (cnt_en) begin
               if (!cnt_dir) begin
                  if (cnt_out == MAX_CNT) begin
                     cnt_nxt   = '0;
                     carry_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt_out + WIDTH'(1);
                  end
               end else begin
                  if (cnt_out == '0) begin
                     cnt_nxt   = MAX_CNT;
                     carry_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt_out - WIDTH'(1);
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state     <= IDLE;
         cnt_out   <= '0;
         carry_out <= 1'b0;
         load_err  <= 1'b0;
         running   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt_out   <= cnt_nxt;
         carry_out <= carry_nxt;
         load_err  <= err_nxt;
         running   <= (state_nxt == RUN);
      end
   end

endmodule

// File: tb/tb_fsm_mod_counter.sv
// Bench for fsm_mod_counter: directed scenarios, parametrised instances, a cascade,
// and a randomized run against an arithmetic reference model.
module tb_fsm_mod_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // default instance (mod 60)
   logic [5:0] din = '0, cnt;
   logic ld = 1'b0, en = 1'b0, dir = 1'b0;
   logic carry, err, run;

   // BCD stage
   logic [3:0] b_din = '0, b_cnt;
   logic b_ld = 1'b0, b_en = 1'b0;
   logic b_carry, b_err, b_run;

   // hours stage
   logic [4:0] h_din = '0, h_cnt;
   logic h_ld = 1'b0, h_en = 1'b0;
   logic h_carry, h_err, h_run;

   // cascade 60 -> 24
   logic [5:0] c0_cnt;
   logic [4:0] c1_cnt;
   logic c_ld = 1'b0, c0_en = 1'b0;
   logic c0_carry, c0_err, c0_run, c1_carry, c1_err, c1_run;

   fsm_mod_counter #(.WIDTH(6), .MODULUS(60)) dut (
      .clk(clk), .rst(rst), .cnt_in(din), .cnt_in_load(ld), .cnt_en(en), .cnt_dir(dir),
      .cnt_out(cnt), .carry_out(carry), .load_err(err), .running(run));

   fsm_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_bcd (
      .clk(clk), .rst(rst), .cnt_in(b_din), .cnt_in_load(b_ld), .cnt_en(b_en), .cnt_dir(1'b0),
      .cnt_out(b_cnt), .carry_out(b_carry), .load_err(b_err), .running(b_run));

   fsm_mod_counter #(.WIDTH(5), .MODULUS(24)) dut_hr (
      .clk(clk), .rst(rst), .cnt_in(h_din), .cnt_in_load(h_ld), .cnt_en(h_en), .cnt_dir(1'b0),
      .cnt_out(h_cnt), .carry_out(h_carry), .load_err(h_err), .running(h_run));

   fsm_mod_counter #(.WIDTH(6), .MODULUS(60)) dut_c0 (
      .clk(clk), .rst(rst), .cnt_in(6'd0), .cnt_in_load(c_ld), .cnt_en(c0_en), .cnt_dir(1'b0),
      .cnt_out(c0_cnt), .carry_out(c0_carry), .load_err(c0_err), .running(c0_run));

   fsm_mod_counter #(.WIDTH(5), .MODULUS(24)) dut_c1 (
      .clk(clk), .rst(rst), .cnt_in(5'd0), .cnt_in_load(c_ld), .cnt_en(c0_carry), .cnt_dir(1'b0),
      .cnt_out(c1_cnt), .carry_out(c1_carry), .load_err(c1_err), .running(c1_run));

   // Reference model: phase 0 = idle, 1 = awaiting load, 2 = running.
   typedef struct {
      int phase;
      int cnt;
      bit carry;
      bit err;
      bit run;
   } mdl_t;

   function automatic mdl_t mdl_next(mdl_t m, int modn, bit r, bit l, int d, bit e, bit dn);
      mdl_t n = m;
      n.carry = 1'b0;
      n.err   = 1'b0;
      if (r) begin
         n.phase = 0;
         n.cnt   = 0;
      end else if (m.phase == 0) begin
         n.phase = 1;
      end else if (l) begin
         if (d < modn) begin
            n.phase = 2;
            n.cnt   = d;
         end else begin
            n.err = 1'b1;
         end
      end else if (m.phase == 2 && e) begin
         if (!dn) begin
            n.cnt   = (m.cnt + 1) % modn;
            n.carry = (m.cnt + 1 == modn);
         end else begin
            n.cnt   = (m.cnt + modn - 1) % modn;
            n.carry = (m.cnt == 0);
         end
      end
      n.run = (n.phase == 2);
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ld = 1'b0; en = 1'b0; dir = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (cnt !== 6'd0 || carry !== 1'b0 || err !== 1'b0 || run !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got cnt=%0d carry=%0b err=%0b run=%0b expected all 0",
                     cnt, carry, err, run);
         end
      end
      rst = 1'b0; ld = 1'b1; din = 6'd5;
      tick();
      n_cmp++;
      if (run !== 1'b0 || cnt !== 6'd0) begin
         n_err++;
         $display("FAIL load_in_idle: got cnt=%0d run=%0b expected cnt=0 run=0", cnt, run);
      end
      tick();
      n_cmp++;
      if (run !== 1'b1 || cnt !== 6'd5) begin
         n_err++;
         $display("FAIL first_load: got cnt=%0d run=%0b expected cnt=5 run=1", cnt, run);
      end
      ld = 1'b0;
   endtask

   task automatic test_up_wrap();
      int  exp_c[4] = '{58, 59, 0, 1};
      bit  exp_k[4] = '{0, 0, 1, 0};
      ld = 1'b1; din = 6'd57; en = 1'b1; dir = 1'b0;
      tick();
      ld = 1'b0;
      n_cmp++;
      if (cnt !== 6'd57 || carry !== 1'b0) begin
         n_err++;
         $display("FAIL up_load: got cnt=%0d carry=%0b expected 57/0", cnt, carry);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (cnt !== 6'(exp_c[i]) || carry !== exp_k[i]) begin
            n_err++;
            $display("FAIL up_wrap[%0d]: got cnt=%0d carry=%0b expected %0d/%0b",
                     i, cnt, carry, exp_c[i], exp_k[i]);
         end
      end
   endtask

   task automatic test_down_wrap();
      int exp_c[3] = '{0, 59, 58};
      bit exp_k[3] = '{0, 1, 0};
      ld = 1'b1; din = 6'd1; en = 1'b0;
      tick();
      ld = 1'b0; en = 1'b1; dir = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (cnt !== 6'(exp_c[i]) || carry !== exp_k[i]) begin
            n_err++;
            $display("FAIL down_wrap[%0d]: got cnt=%0d carry=%0b expected %0d/%0b",
                     i, cnt, carry, exp_c[i], exp_k[i]);
         end
      end
      dir = 1'b0;
      tick();
      n_cmp++;
      if (cnt !== 6'd59 || carry !== 1'b0) begin
         n_err++;
         $display("FAIL dir_flip: got cnt=%0d carry=%0b expected 59/0", cnt, carry);
      end
      tick();
      n_cmp++;
      if (cnt !== 6'd0 || carry !== 1'b1) begin
         n_err++;
         $display("FAIL dir_flip_wrap: got cnt=%0d carry=%0b expected 0/1", cnt, carry);
      end
      en = 1'b0;
   endtask

   task automatic test_load_range();
      rst = 1'b1; ld = 1'b0; en = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      ld = 1'b1; din = 6'd60;
      tick();
      n_cmp++;
      if (err !== 1'b1 || run !== 1'b0 || cnt !== 6'd0) begin
         n_err++;
         $display("FAIL wait_reject: got err=%0b run=%0b cnt=%0d expected 1/0/0", err, run, cnt);
      end
      ld = 1'b0;
      tick();
      n_cmp++;
      if (err !== 1'b0 || run !== 1'b0) begin
         n_err++;
         $display("FAIL wait_reject_pulse: got err=%0b run=%0b expected 0/0", err, run);
      end
      ld = 1'b1; din = 6'd20;
      tick();
      ld = 1'b1; din = 6'd63; en = 1'b1; dir = 1'b0;
      tick();
      n_cmp++;
      if (err !== 1'b1 || cnt !== 6'd20 || carry !== 1'b0 || run !== 1'b1) begin
         n_err++;
         $display("FAIL run_reject: got err=%0b cnt=%0d carry=%0b run=%0b expected 1/20/0/1",
                  err, cnt, carry, run);
      end
      ld = 1'b0;
      tick();
      n_cmp++;
      if (err !== 1'b0 || cnt !== 6'd21) begin
         n_err++;
         $display("FAIL run_reject_after: got err=%0b cnt=%0d expected 0/21", err, cnt);
      end
      en = 1'b0;
   endtask

   task automatic test_priority();
      ld = 1'b1; din = 6'd59; en = 1'b0;
      tick();
      din = 6'd10; en = 1'b1; dir = 1'b0;
      tick();
      ld = 1'b0;
      n_cmp++;
      if (cnt !== 6'd10 || carry !== 1'b0) begin
         n_err++;
         $display("FAIL load_over_count: got cnt=%0d carry=%0b expected 10/0", cnt, carry);
      end
      repeat (23) tick();
      n_cmp++;
      if (cnt !== 6'd33) begin
         n_err++;
         $display("FAIL count_to_33: got cnt=%0d expected 33", cnt);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      n_cmp++;
      if (cnt !== 6'd0 || run !== 1'b0 || carry !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL mid_run_reset: got cnt=%0d run=%0b carry=%0b err=%0b expected all 0",
                  cnt, run, carry, err);
      end
   endtask

   task automatic bring_up_all();
      rst = 1'b1; ld = 1'b0; b_ld = 1'b0; h_ld = 1'b0; c_ld = 1'b0;
      en = 1'b0; b_en = 1'b0; h_en = 1'b0; c0_en = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      b_ld = 1'b1; b_din = 4'd0; h_ld = 1'b1; h_din = 5'd0; c_ld = 1'b1;
      tick();
      b_ld = 1'b0; h_ld = 1'b0; c_ld = 1'b0;
   endtask

   task automatic test_param();
      int b_carries = 0;
      int h_carries = 0;
      bring_up_all();
      b_en = 1'b1; h_en = 1'b1;
      for (int i = 0; i < 48; i++) begin
         tick();
         if (i < 20 && b_carry === 1'b1) b_carries++;
         if (h_carry === 1'b1) h_carries++;
         n_cmp++;
         if (b_cnt !== 4'((i + 1) % 10) || b_cnt >= 4'd10) begin
            n_err++;
            $display("FAIL bcd_count[%0d]: got %0d expected %0d", i, b_cnt, (i + 1) % 10);
         end
         n_cmp++;
         if (h_cnt !== 5'((i + 1) % 24) || h_cnt >= 5'd24) begin
            n_err++;
            $display("FAIL hour_count[%0d]: got %0d expected %0d", i, h_cnt, (i + 1) % 24);
         end
      end
      n_cmp++;
      if (b_carries != 2) begin
         n_err++;
         $display("FAIL bcd_carries: got %0d expected 2", b_carries);
      end
      n_cmp++;
      if (h_carries != 2) begin
         n_err++;
         $display("FAIL hour_carries: got %0d expected 2", h_carries);
      end
      b_en = 1'b0; h_en = 1'b0;
   endtask

   task automatic test_cascade();
      bring_up_all();
      c0_en = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         n_cmp++;
         if (c0_cnt !== 6'(k % 60) || c1_cnt !== 5'(((k - 1) / 60) % 24)) begin
            n_err++;
            $display("FAIL cascade[%0d]: got %0d:%0d expected %0d:%0d",
                     k, c1_cnt, c0_cnt, ((k - 1) / 60) % 24, k % 60);
         end
      end
      c0_en = 1'b0;
   endtask

   task automatic test_random();
      mdl_t m;
      bit   r;
      m = '{phase: 0, cnt: 0, carry: 1'b0, err: 1'b0, run: 1'b0};
      rst = 1'b1; ld = 1'b0; en = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 79) == 0);
         rst = r;
         ld  = ($urandom_range(0, 5) == 0);
         din = 6'($urandom_range(0, 63));
         en  = ($urandom_range(0, 3) != 0);
         dir = 1'($urandom_range(0, 1));
         tick();
         m = mdl_next(m, 60, r, ld, int'(din), en, dir);
         n_cmp++;
         if (cnt !== 6'(m.cnt) || carry !== m.carry || err !== m.err || run !== m.run) begin
            n_err++;
            $display("FAIL random[%0d]: got cnt=%0d carry=%0b err=%0b run=%0b expected %0d/%0b/%0b/%0b",
                     i, cnt, carry, err, run, m.cnt, m.carry, m.err, m.run);
         end
      end
      rst = 1'b0; ld = 1'b0; en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load_range();
      test_priority();
      test_param();
      test_cascade();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fsm_mod_counter.md
# fsm_mod_counter

Parametrised modulo counter with a load/run state machine, for the FSM micro-benchmark family: a generalisation of the fixed 6-bit seconds counter, usable as seconds, minutes, hours or any mod-N stage. It adds a configurable width and modulus, count enable, up/down direction, a wrap pulse for cascading stages, and range-checked loading. Counter value and flags are registered, so stages chain directly: `carry_out` of one stage drives `cnt_en` of the next.

## Interface
- `WIDTH`, default 6: counter width in bits.
- `MODULUS`, default 60: count range is 0..MODULUS-1. Constraint: 2 <= MODULUS <= 2**WIDTH.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `cnt_in`  in  WIDTH  value to load.
- `cnt_in_load`  in  1  load strobe, sampled each clock.
- `cnt_en`  in  1  count enable (one step per cycle when high).
- `cnt_dir`  in  1  0 = count up, 1 = count down.
- `cnt_out`  out  WIDTH  registered count value.
- `carry_out`  out  1  one-cycle pulse on wrap (up: MODULUS-1→0; down: 0→MODULUS-1).
- `load_err`  out  1  one-cycle pulse when a load is rejected (`cnt_in` >= MODULUS).
- `running`  out  1  high while in state RUN.

## Operation
- State machine, registered state, three states:
  - IDLE (reset state) → WAIT_LOAD unconditionally on the next clock. Loads are ignored in IDLE.
  - WAIT_LOAD: `cnt_en` is ignored.
    - Valid load → RUN, count <= `cnt_in`.
    - Rejected load → stay in WAIT_LOAD, `load_err` pulses.
    - No load → stay.
  - RUN: stays in RUN until reset.
    - Valid load: count <= `cnt_in`.
    - Rejected load: count unchanged, `load_err` pulses.
    - Otherwise, if `cnt_en`: one step in direction `cnt_dir`.
  - Encodings for unused state values fall back to IDLE on the next clock, with count cleared to 0.
- Priority within a cycle: `rst` > `cnt_in_load` > `cnt_en`.
  - A rejected load still blocks counting that cycle.
  - A load never produces `carry_out`.
- Arithmetic: WIDTH-bit, modulo MODULUS; no intermediate value outside 0..MODULUS-1 is ever registered.
  - Up: count == MODULUS-1 → 0 with `carry_out`=1; else count+1.
  - Down: count == 0 → MODULUS-1 with `carry_out`=1; else count-1.
- `cnt_dir` may change on any cycle and takes effect for that cycle's step.
- `running` = (state == RUN), registered.

## Timing
- Reset (synchronous, high at a rising edge) sets:
  - state = IDLE;
  - `cnt_out`, `carry_out`, `load_err` and `running` all = 0.
- Reset asserted mid-RUN behaves identically; the in-progress count is discarded.
- After `rst` deasserts: first edge IDLE→WAIT_LOAD; the earliest accepted load is at the second edge.
- Load latency: strobe sampled at edge N; `cnt_out` = `cnt_in` and `running`=1 after edge N.
- Count latency: `cnt_en` sampled at edge N; new value on `cnt_out` after edge N.
- `carry_out` and `load_err` are registered and are high exactly for the cycle following the causing edge. Consecutive wraps, e.g. MODULUS=2 with `cnt_en` held high, give back-to-back pulses.
- With `cnt_en` held high, the count advances every cycle; there is no internal prescaler.

## Test plan
- Reset/bring-up: `rst` for 2 cycles, then low; `cnt_in_load`=1 with `cnt_in`=5 on the first post-reset edge → ignored (IDLE), stays WAIT_LOAD. Same load on the next edge → `cnt_out`=5, `running`=1. All outputs are 0 during reset.
- Up wrap (defaults): load 57, `cnt_en`=1, `cnt_dir`=0 → `cnt_out` 58, 59, 0, 1; `carry_out`=1 only in the cycle `cnt_out` first shows 0.
- Down wrap: load 1, `cnt_dir`=1, `cnt_en`=1 → 0, 59, 58; one `carry_out` pulse coincident with 59. Flip `cnt_dir` to 0 mid-run → next value increments from current.
- Load range check: in WAIT_LOAD, load 60 → `load_err` pulse, remains WAIT_LOAD, `running`=0. In RUN at 20 with `cnt_en`=1, load 63 → `load_err`=1, `cnt_out` stays 20 that cycle.
- Priority: in RUN at 59 with up-count enabled, `cnt_en`=1 and load 10 together → `cnt_out`=10, `carry_out`=0. Reset asserted at 33 mid-count → `cnt_out`=0, `running`=0 next cycle.
- Parametrisation: WIDTH=4, MODULUS=10 (BCD) and WIDTH=5, MODULUS=24 (hours). Free-run up for 2×MODULUS cycles → exactly 2 `carry_out` pulses, `cnt_out` never >= MODULUS. Cascade two instances (60 feeding 24) → second stage increments once per 60 enabled cycles.
